// File: rtl/urv_iram_loader.sv
// Byte-stream IRAM loader: host commands set an address, write words, or read words back LSB first.
// Defining URV_IRAM_LOADER_CHECKSUM_EN adds a running XOR checksum of written bytes (command 0x04).
module urv_iram_loader #(
    parameter int g_size = 65536
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_bwe_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i,
    output logic        busy_o,
    output logic        err_o
);

    // Keeps addresses word aligned and inside the IRAM in one AND.
    localparam logic [31:0] ADDR_MASK = (32'(g_size) - 32'd1) & ~32'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_WRITE,
        S_RD_REQ,
        S_RD_WAIT,
`ifdef URV_IRAM_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_TX
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] shift_q, shift_d;
    logic        err_q, err_d;
    logic        rx_fire, tx_fire;
`ifdef URV_IRAM_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    assign rx_fire    = rx_valid_i && rx_ready_o;
    assign tx_fire    = tx_valid_o && tx_ready_i;
    assign mem_addr_o = addr_q;
    assign mem_data_o = wdata_q;
    assign busy_o     = (state_q != S_IDLE);
    assign err_o      = err_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            wdata_q <= '0;
            shift_q <= '0;
            err_q   <= 1'b0;
`ifdef URV_IRAM_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
            shift_q <= shift_d;
            err_q   <= err_d;
`ifdef URV_IRAM_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        wdata_d    = wdata_q;
        shift_d    = shift_q;
        err_d      = 1'b0;
        rx_ready_o = 1'b0;
        tx_valid_o = 1'b0;
        tx_data_o  = 8'h00;
        mem_en_o   = 1'b0;
        mem_we_o   = 1'b0;
        mem_bwe_o  = 4'h0;
`ifdef URV_IRAM_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif

        case (state_q)
            S_IDLE: begin
                rx_ready_o = 1'b1;
                if (rx_fire) begin
                    cnt_d = 2'd0;
                    case (rx_data_i)
                        8'h01: begin
                            state_d = S_ADDR;
`ifdef URV_IRAM_LOADER_CHECKSUM_EN
                            csum_d  = 8'h00;
`endif
                        end
                        8'h02: state_d = S_WDATA;
                        8'h03: state_d = S_RD_REQ;
`ifdef URV_IRAM_LOADER_CHECKSUM_EN
                        8'h04: state_d = S_CSUM;
`endif
                        default: err_d = 1'b1;
                    endcase
                end
            end

            // The address is assembled in the read shift register so the
            // visible address only changes once all four bytes have arrived.
            S_ADDR: begin
                rx_ready_o = 1'b1;
                if (rx_fire) begin
                    shift_d = {rx_data_i, shift_q[31:8]};
                    if (cnt_q == 2'd3) begin
                        addr_d  = {rx_data_i, shift_q[31:8]} & ADDR_MASK;
                        cnt_d   = 2'd0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end

            S_WDATA: begin
                rx_ready_o = 1'b1;
                if (rx_fire) begin
                    wdata_d = {rx_data_i, wdata_q[31:8]};
`ifdef URV_IRAM_LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ rx_data_i;
`endif
                    if (cnt_q == 2'd3) begin
                        cnt_d   = 2'd0;
                        state_d = S_WRITE;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end

            S_WRITE: begin
                mem_en_o  = 1'b1;
                mem_we_o  = 1'b1;
                mem_bwe_o = 4'hF;
                addr_d    = (addr_q + 32'd4) & ADDR_MASK;
                cnt_d     = 2'd0;
                state_d   = S_IDLE;
            end

            S_RD_REQ: begin
                mem_en_o = 1'b1;
                cnt_d    = 2'd0;
                state_d  = S_RD_WAIT;
            end

            S_RD_WAIT: begin
                shift_d = mem_data_i;
                cnt_d   = 2'd0;
                state_d = S_TX;
            end

            S_TX: begin
                tx_valid_o = 1'b1;
                tx_data_o  = shift_q[7:0];
                if (tx_fire) begin
                    shift_d = {8'h00, shift_q[31:8]};
                    if (cnt_q == 2'd3) begin
                        addr_d  = (addr_q + 32'd4) & ADDR_MASK;
                        cnt_d   = 2'd0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end

`ifdef URV_IRAM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                tx_valid_o = 1'b1;
                tx_data_o  = csum_q;
                if (tx_fire) begin
                    csum_d  = 8'h00;
                    cnt_d   = 2'd0;
                    state_d = S_IDLE;
                end
            end
`endif

            default: begin
                cnt_d   = 2'd0;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/urv_iram_loader.md
URV_IRAM_LOADER -- requirements
Module: urv_iram_loader

Interface
REQ-001 SHALL have parameter g_size, default 65536, IRAM size in bytes (power of two); address wraps modulo g_size.
REQ-002 SHALL have ports (name  direction  width  meaning):
 clk_i  in  1  single clock, all logic rising-edge
 rst_n_i  in  1  reset, asynchronous, active-low
 rx_data_i  in  8  host command/data byte
 rx_valid_i  in  1  rx byte valid
 rx_ready_o  out  1  loader accepts rx byte
 tx_data_o  out  8  response byte
 tx_valid_o  out  1  response byte valid
 tx_ready_i  in  1  host accepts tx byte
 mem_en_o  out  1  IRAM port enable
 mem_we_o  out  1  IRAM write enable
 mem_addr_o  out  32  IRAM byte address, bits [1:0] always 0
 mem_bwe_o  out  4  IRAM byte write enables
 mem_data_o  out  32  IRAM write data
 mem_data_i  in  32  IRAM read data, valid one cycle after mem_en_o
 busy_o  out  1  high whenever state is not IDLE
 err_o  out  1  one-cycle pulse on unknown command

Function
REQ-003 SHALL transfer an rx byte only in a cycle where rx_valid_i and rx_ready_o are both high; likewise tx with tx_valid_i/tx_ready_i.
REQ-004 SHALL implement states IDLE, ADDR, WDATA, WRITE, RD_REQ, RD_WAIT, TX, and CSUM (CSUM only with REQ-016 macro).
REQ-005 SHALL drive rx_ready_o high only in IDLE, ADDR and WDATA.
REQ-006 IDLE: command byte 0x01 -> ADDR; 0x02 -> WDATA; 0x03 -> RD_REQ; any other -> stay IDLE, err_o high next cycle for exactly one cycle.
REQ-007 ADDR: SHALL collect 4 bytes little-endian; after 4th, address register = value with bits [1:0] cleared, modulo g_size; return to IDLE.
REQ-008 WDATA: SHALL collect 4 bytes little-endian into mem_data_o; after 4th, go to WRITE.
REQ-009 WRITE: SHALL assert mem_en_o, mem_we_o, mem_bwe_o=4'hF for exactly one cycle at current address, then address += 4 modulo g_size, go to IDLE.
REQ-010 RD_REQ: SHALL assert mem_en_o with mem_we_o=0, mem_bwe_o=0 for one cycle; RD_WAIT captures mem_data_i into a 32-bit shift register; then TX.
REQ-011 TX: SHALL present 4 bytes LSB first; tx_data_o stable and tx_valid_o held while tx_ready_i low; after 4th accepted byte, address += 4 modulo g_size, go to IDLE.
REQ-012 mem_en_o, mem_we_o, mem_bwe_o SHALL be 0 in every state other than WRITE and RD_REQ; mem_addr_o always reflects the address register.
REQ-013 Address wrap: g_size-4 + 4 SHALL yield 0.
REQ-014 Byte counter SHALL be 2 bits, cleared on every state entry; no partial-word write ever issued.

Reset
REQ-015 On rst_n_i low, immediately: state IDLE, address 0, byte counter 0, data/shift registers 0, all outputs 0 except rx_ready_o=1 after release; partial commands and pending tx bytes discarded; no IRAM access after reset until a new complete command.

Configuration
REQ-016 Macro URV_IRAM_LOADER_CHECKSUM_EN: when defined, SHALL keep an 8-bit XOR of every data byte accepted in WDATA; command 0x04 -> CSUM, which sends the checksum as one tx byte then clears it and returns to IDLE; checksum cleared by reset and by command 0x01. When undefined, no checksum logic exists and 0x04 is an unknown command (REQ-006).

Verification
REQ-017 Rx 01 10 00 00 00, 02 EF BE AD DE -> one write cycle: mem_addr_o=0x10, mem_data_o=0xDEADBEEF, mem_bwe_o=F; address becomes 0x14.
REQ-018 After REQ-017, rx 01 10 00 00 00, 03 with IRAM returning 0xDEADBEEF -> tx EF BE AD DE in order; tx_ready_i held low 5 cycles mid-byte leaves tx_data_o unchanged.
REQ-019 Rx 01 FD FF 00 00 (g_size=65536) then two 02 writes -> addresses 0xFFFC then 0x0000.
REQ-020 Rx 0x55 -> err_o high one cycle, no mem_en_o, next 01 command accepted normally.
REQ-021 rst_n_i pulsed after 02 AA BB -> no write occurs; subsequent 02 11 22 33 44 writes 0x44332211 at address 0.
REQ-022 With URV_IRAM_LOADER_CHECKSUM_EN: write 0x04030201 then rx 04 -> tx 0x04, second 04 -> tx 0x00; without macro, 04 -> err_o pulse.
